// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller: synchronised level/edge sources, fixed-priority claim/complete, prescaled 64-bit timer.
// Reads return one cycle after re_i; writes land on the strobe edge; the bus slave never stalls.
module intr_ctrl #(
  parameter int DW         = 32,
  parameter int NUM_SRC    = 8,
  parameter int IDW        = $clog2(NUM_SRC + 1),
  parameter int PRESCALE_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [3:0]         addr_i,
  input  logic [DW-1:0]      wdata_i,
  output logic [DW-1:0]      rdata_o,
  output logic               t_intr_o,
  output logic               e_intr_o,
  output logic [IDW-1:0]     claim_id_o
);

  localparam logic [3:0] A_ENABLE   = 4'd0;
  localparam logic [3:0] A_EDGE     = 4'd1;
  localparam logic [3:0] A_PENDING  = 4'd2;
  localparam logic [3:0] A_INSVC    = 4'd3;
  localparam logic [3:0] A_PRESCALE = 4'd4;
  localparam logic [3:0] A_MTIME_LO = 4'd5;
  localparam logic [3:0] A_MTIME_HI = 4'd6;
  localparam logic [3:0] A_CMP_LO   = 4'd7;
  localparam logic [3:0] A_CMP_HI   = 4'd8;
  localparam logic [3:0] A_CLAIM    = 4'd9;

  logic [NUM_SRC-1:0]    sync1, sync2, sync3;
  logic [NUM_SRC-1:0]    enable, edge_mode, pending, insvc;
  logic [NUM_SRC-1:0]    rise, w1c, claim_oh, cmpl_oh, present;
  logic [NUM_SRC-1:0]    pending_nxt;
  logic [PRESCALE_W-1:0] prescale, presc_cnt;
  logic [63:0]           mtime, mtimecmp;
  logic [IDW-1:0]        pri_id, cmpl_id;
  logic [DW-1:0]         rd_val;
  logic [31:0]           wd32;
  logic                  claim_rd, cmpl_wr, presc_rst, tick;

  assign wd32     = wdata_i[31:0];
  assign cmpl_id  = wdata_i[IDW-1:0];
  assign claim_rd = re_i && (addr_i == A_CLAIM);
  assign cmpl_wr  = we_i && (addr_i == A_CLAIM);
  assign rise     = sync2 & ~sync3;
  assign w1c      = (we_i && addr_i == A_PENDING) ? wdata_i[NUM_SRC-1:0] : '0;
  assign present  = pending & enable & ~insvc;

  // Decoded one-hots: ID 0 and IDs above NUM_SRC match no source, so they fall out naturally.
  always_comb begin
    claim_oh = '0;
    cmpl_oh  = '0;
    pri_id   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_oh[i] = claim_rd && (claim_id_o == IDW'(i + 1));
      cmpl_oh[i]  = cmpl_wr && (cmpl_id == IDW'(i + 1));
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (present[i]) pri_id = IDW'(i + 1);
    end
  end

  // A fresh edge beats both W1C and claim-clear, so a late edge is never lost.
  assign pending_nxt = (edge_mode & ((pending & ~w1c & ~claim_oh) | rise))
                     | (~edge_mode & sync2);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1      <= '0;
      sync2      <= '0;
      sync3      <= '0;
      pending    <= '0;
      insvc      <= '0;
      enable     <= '0;
      edge_mode  <= '0;
      e_intr_o   <= 1'b0;
      claim_id_o <= '0;
    end else begin
      sync1      <= src_i;
      sync2      <= sync1;
      sync3      <= sync2;
      pending    <= pending_nxt;
      insvc      <= (insvc & ~cmpl_oh) | claim_oh;
      e_intr_o   <= |present;
      claim_id_o <= pri_id;
      if (we_i && addr_i == A_ENABLE) enable    <= wdata_i[NUM_SRC-1:0];
      if (we_i && addr_i == A_EDGE)   edge_mode <= wdata_i[NUM_SRC-1:0];
    end
  end

  assign presc_rst = we_i && (addr_i == A_PRESCALE || addr_i == A_MTIME_LO || addr_i == A_MTIME_HI);
  assign tick      = (presc_cnt == prescale) && !presc_rst;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prescale  <= '0;
      presc_cnt <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      t_intr_o  <= 1'b0;
    end else begin
      t_intr_o <= (mtime >= mtimecmp);
      if (presc_rst || tick) presc_cnt <= '0;
      else                   presc_cnt <= presc_cnt + PRESCALE_W'(1);
      if (we_i && addr_i == A_PRESCALE) prescale <= wdata_i[PRESCALE_W-1:0];
      // A bus write to either half suppresses that cycle's increment entirely.
      if (we_i && addr_i == A_MTIME_LO)      mtime[31:0]  <= wd32;
      else if (we_i && addr_i == A_MTIME_HI) mtime[63:32] <= wd32;
      else if (tick)                         mtime        <= mtime + 64'd1;
      if (we_i && addr_i == A_CMP_LO) mtimecmp[31:0]  <= wd32;
      if (we_i && addr_i == A_CMP_HI) mtimecmp[63:32] <= wd32;
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr_i)
      A_ENABLE:   rd_val[NUM_SRC-1:0]    = enable;
      A_EDGE:     rd_val[NUM_SRC-1:0]    = edge_mode;
      A_PENDING:  rd_val[NUM_SRC-1:0]    = pending;
      A_INSVC:    rd_val[NUM_SRC-1:0]    = insvc;
      A_PRESCALE: rd_val[PRESCALE_W-1:0] = prescale;
      A_MTIME_LO: rd_val[31:0]           = mtime[31:0];
      A_MTIME_HI: rd_val[31:0]           = mtime[63:32];
      A_CMP_LO:   rd_val[31:0]           = mtimecmp[31:0];
      A_CMP_HI:   rd_val[31:0]           = mtimecmp[63:32];
      A_CLAIM:    rd_val[IDW-1:0]        = claim_id_o;
      default:    rd_val                 = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    rdata_o <= '0;
    else if (re_i) rdata_o <= rd_val;
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed walk through the documented scenarios, then randomized bus/source traffic against a reference model.
module tb_intr_ctrl;
  localparam int NS  = 8;
  localparam int IDW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [NS-1:0] src_i = '0;
  logic          we_i = 1'b0, re_i = 1'b0;
  logic [3:0]    addr_i = '0;
  logic [31:0]   wdata_i = '0;
  logic [31:0]   rdata_o;
  logic          t_intr_o, e_intr_o;
  logic [IDW-1:0] claim_id_o;

  int n_vec = 0;
  int n_err = 0;

  intr_ctrl #(.DW(32), .NUM_SRC(NS), .IDW(IDW), .PRESCALE_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .src_i(src_i), .we_i(we_i), .re_i(re_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .t_intr_o(t_intr_o), .e_intr_o(e_intr_o), .claim_id_o(claim_id_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk_i);
    we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    re_i = 1'b1; addr_i = a;
    @(negedge clk_i);
    re_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic check_reset_regs();
    logic [31:0] d;
    logic [3:0]  addrs [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd9, 4'd12, 4'd8};
    logic [31:0] exps  [10] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF};
    check("rst t_intr", 64'(t_intr_o), 64'd0);
    check("rst e_intr", 64'(e_intr_o), 64'd0);
    check("rst claim_id", 64'(claim_id_o), 64'd0);
    check("rst rdata", 64'(rdata_o), 64'd0);
    // mtime free-runs with PRESCALE=0, so it is only zero on the very first read.
    bus_read(4'd5, d);
    check("rst mtime_lo", 64'(d), 64'd0);
    for (int i = 0; i < 10; i++) begin
      bus_read(addrs[i], d);
      check($sformatf("rst reg%0d", addrs[i]), 64'(d), 64'(exps[i]));
    end
    @(negedge clk_i);
    check("rdata hold", 64'(rdata_o), 64'hFFFF_FFFF);
  endtask

  // Reference model state
  logic [NS-1:0]  m_hist [3];
  logic [NS-1:0]  m_en, m_edge, m_pend, m_insvc;
  logic [7:0]     m_pre;
  logic [63:0]    m_time, m_cmp;
  longint         m_age;
  logic [31:0]    m_rdata;
  logic           m_t, m_e;
  logic [IDW-1:0] m_claim;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    m_en = '0; m_edge = '0; m_pend = '0; m_insvc = '0;
    m_pre = '0; m_time = '0; m_cmp = '1; m_age = 0;
    m_rdata = '0; m_t = 1'b0; m_e = 1'b0; m_claim = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    int best = 0;
    int claimed = 0;
    int cid;
    logic [NS-1:0] np, ni;
    for (int i = NS - 1; i >= 0; i--)
      if (m_pend[i] && m_en[i] && !m_insvc[i]) best = i + 1;
    if (re_i) begin
      case (addr_i)
        4'd0: m_rdata = 32'(m_en);
        4'd1: m_rdata = 32'(m_edge);
        4'd2: m_rdata = 32'(m_pend);
        4'd3: m_rdata = 32'(m_insvc);
        4'd4: m_rdata = 32'(m_pre);
        4'd5: m_rdata = m_time[31:0];
        4'd6: m_rdata = m_time[63:32];
        4'd7: m_rdata = m_cmp[31:0];
        4'd8: m_rdata = m_cmp[63:32];
        4'd9: m_rdata = 32'(m_claim);
        default: m_rdata = 32'd0;
      endcase
      if (addr_i == 4'd9) claimed = int'(m_claim);
    end
    np = m_pend;
    ni = m_insvc;
    for (int i = 0; i < NS; i++) begin
      if (m_edge[i]) begin
        if (we_i && addr_i == 4'd2 && wdata_i[i]) np[i] = 1'b0;
        if (claimed == i + 1) np[i] = 1'b0;
        if (m_hist[1][i] && !m_hist[2][i]) np[i] = 1'b1;
      end else begin
        np[i] = m_hist[1][i];
      end
    end
    cid = int'(wdata_i[IDW-1:0]);
    if (we_i && addr_i == 4'd9 && cid >= 1 && cid <= NS) ni[cid-1] = 1'b0;
    if (claimed != 0) ni[claimed-1] = 1'b1;
    m_t = (m_time >= m_cmp);
    if (we_i && (addr_i == 4'd4 || addr_i == 4'd5 || addr_i == 4'd6)) begin
      m_age = 0;
      if (addr_i == 4'd4) m_pre = wdata_i[7:0];
      if (addr_i == 4'd5) m_time[31:0] = wdata_i;
      if (addr_i == 4'd6) m_time[63:32] = wdata_i;
    end else begin
      if (m_age % (longint'(m_pre) + 1) == longint'(m_pre)) m_time = m_time + 64'd1;
      m_age++;
    end
    if (we_i && addr_i == 4'd7) m_cmp[31:0]  = wdata_i;
    if (we_i && addr_i == 4'd8) m_cmp[63:32] = wdata_i;
    if (we_i && addr_i == 4'd0) m_en   = wdata_i[NS-1:0];
    if (we_i && addr_i == 4'd1) m_edge = wdata_i[NS-1:0];
    m_pend  = np;
    m_insvc = ni;
    m_e     = (best != 0);
    m_claim = IDW'(best);
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = src_i;
  endtask

  initial begin
    logic [31:0] d;
    repeat (3) @(negedge clk_i);
    check("in-reset e_intr", 64'(e_intr_o), 64'd0);
    rst_i = 1'b1;
    check_reset_regs();

    // Edge mode, two simultaneous sources: lowest index first.
    bus_write(4'd1, 32'hFF);
    bus_write(4'd0, 32'h14);
    src_i = 8'h14;
    repeat (3) @(negedge clk_i);
    check("edge lat3 e_intr", 64'(e_intr_o), 64'd0);
    @(negedge clk_i);
    check("edge lat4 e_intr", 64'(e_intr_o), 64'd1);
    check("edge lat4 claim", 64'(claim_id_o), 64'd3);
    src_i = '0;
    bus_read(4'd9, d);
    check("edge claim 3", 64'(d), 64'd3);
    @(negedge clk_i);
    check("edge next claim", 64'(claim_id_o), 64'd5);
    bus_read(4'd9, d);
    check("edge claim 5", 64'(d), 64'd5);
    @(negedge clk_i);
    check("edge e after claims", 64'(e_intr_o), 64'd0);
    bus_read(4'd3, d);
    check("edge insvc", 64'(d), 64'h14);
    bus_read(4'd2, d);
    check("edge pending cleared", 64'(d), 64'h0);
    bus_write(4'd9, 32'd3);
    bus_write(4'd9, 32'd5);
    bus_read(4'd3, d);
    check("edge insvc done", 64'(d), 64'h0);

    // Level mode: a still-high source comes back after complete.
    bus_write(4'd1, 32'h0);
    bus_write(4'd0, 32'h1);
    src_i = 8'h01;
    repeat (5) @(negedge clk_i);
    check("lvl e_intr", 64'(e_intr_o), 64'd1);
    bus_read(4'd9, d);
    check("lvl claim", 64'(d), 64'd1);
    @(negedge clk_i);
    check("lvl e after claim", 64'(e_intr_o), 64'd0);
    bus_write(4'd9, 32'd1);
    check("lvl e at complete", 64'(e_intr_o), 64'd0);
    @(negedge clk_i);
    check("lvl re-present", 64'(e_intr_o), 64'd1);
    src_i = '0;
    repeat (3) @(negedge clk_i);
    check("lvl drop lat3", 64'(e_intr_o), 64'd1);
    @(negedge clk_i);
    check("lvl drop lat4", 64'(e_intr_o), 64'd0);
    bus_read(4'd2, d);
    check("lvl pending", 64'(d), 64'h0);

    // Timer with prescale 3: one tick per 4 cycles.
    bus_write(4'd4, 32'd3);
    bus_write(4'd7, 32'd5);
    bus_write(4'd8, 32'd0);
    bus_write(4'd6, 32'd0);
    bus_write(4'd5, 32'd0);
    for (int k = 1; k <= 24; k++) begin
      bus_read(4'd5, d);
      check($sformatf("tmr mtime k%0d", k), 64'(d), 64'((k - 1) / 4));
      check($sformatf("tmr t_intr k%0d", k), 64'(t_intr_o), 64'(k >= 21));
    end
    bus_write(4'd7, 32'd100);
    check("tmr cmp old", 64'(t_intr_o), 64'd1);
    @(negedge clk_i);
    check("tmr cmp new", 64'(t_intr_o), 64'd0);

    // 64-bit wrap.
    bus_write(4'd4, 32'd0);
    bus_write(4'd6, 32'hFFFF_FFFF);
    bus_write(4'd5, 32'hFFFF_FFFF);
    bus_read(4'd5, d);
    check("wrap lo max", 64'(d), 64'hFFFF_FFFF);
    bus_read(4'd6, d);
    check("wrap hi", 64'(d), 64'd0);
    bus_read(4'd5, d);
    check("wrap lo", 64'(d), 64'd1);

    // W1C colliding with a fresh edge on the same bit.
    bus_write(4'd0, 32'h0);
    bus_write(4'd1, 32'hFF);
    src_i = 8'h02;
    repeat (3) @(negedge clk_i);
    src_i = '0;
    repeat (4) @(negedge clk_i);
    bus_read(4'd2, d);
    check("w1c setup", 64'(d), 64'h02);
    src_i = 8'h02;
    repeat (2) @(negedge clk_i);
    bus_write(4'd2, 32'h02);
    src_i = '0;
    repeat (4) @(negedge clk_i);
    bus_read(4'd2, d);
    check("w1c vs edge", 64'(d), 64'h02);
    bus_write(4'd2, 32'h02);
    bus_read(4'd2, d);
    check("w1c plain", 64'(d), 64'h00);

    // Ignored completes, then async reset mid-claim.
    bus_write(4'd0, 32'h0C);
    src_i = 8'h0C;
    repeat (4) @(negedge clk_i);
    src_i = '0;
    check("ar claim id", 64'(claim_id_o), 64'd3);
    bus_read(4'd9, d);
    check("ar claim", 64'(d), 64'd3);
    @(negedge clk_i);
    check("ar next claim", 64'(claim_id_o), 64'd4);
    bus_write(4'd9, 32'd0);
    bus_write(4'd9, 32'd9);
    bus_write(4'd9, 32'd4);
    bus_read(4'd3, d);
    check("cmpl ignored insvc", 64'(d), 64'h04);
    check("ar e_intr before", 64'(e_intr_o), 64'd1);
    #2 rst_i = 1'b0;
    #1;
    check("ar rdata", 64'(rdata_o), 64'd0);
    check("ar t_intr", 64'(t_intr_o), 64'd0);
    check("ar e_intr", 64'(e_intr_o), 64'd0);
    check("ar claim_id", 64'(claim_id_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    check_reset_regs();

    // Randomized traffic against the model.
    rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      src_i  = src_i ^ NS'($urandom & $urandom & $urandom);
      we_i   = ($urandom_range(0, 3) == 0);
      re_i   = ($urandom_range(0, 1) == 0);
      addr_i = 4'($urandom_range(0, 11));
      case (addr_i)
        4'd4:       wdata_i = $urandom_range(0, 6);
        4'd5, 4'd7: wdata_i = $urandom_range(0, 60);
        4'd6, 4'd8: wdata_i = $urandom_range(0, 1);
        4'd9:       wdata_i = $urandom_range(0, 10);
        default:    wdata_i = $urandom;
      endcase
      model_step();
      @(negedge clk_i);
      check("rnd rdata", 64'(rdata_o), 64'(m_rdata));
      check("rnd t_intr", 64'(t_intr_o), 64'(m_t));
      check("rnd e_intr", 64'(e_intr_o), 64'(m_e));
      check("rnd claim_id", 64'(claim_id_o), 64'(m_claim));
    end
    we_i = 1'b0;
    re_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
